// File: rtl/key_counter_pkg.sv
// Shared types and constants for the key_counter push-button counter.
package key_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        HELD,
        CHK_REL
    } db_state_e;

    localparam logic [7:0] BIN_MAX = 8'hFF;
    localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/key_counter_if.sv
// Key/load inputs and count outputs of key_counter, bundled for the top-level port.
interface key_counter_if;

    logic       KEY_UP_N;
    logic       KEY_DN_N;
    logic       LOAD;
    logic [7:0] LOAD_VAL;
    logic [7:0] VALUE;
    logic       STEP;
    logic       WRAP;

    modport master (
        output KEY_UP_N, KEY_DN_N, LOAD, LOAD_VAL,
        input  VALUE, STEP, WRAP
    );

    modport slave (
        input  KEY_UP_N, KEY_DN_N, LOAD, LOAD_VAL,
        output VALUE, STEP, WRAP
    );

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, debounce FSM and stability counter.
// Emits a single-cycle press_evt once a press has been stable for DEBOUNCE_CYCLES.
module key_debounce
    import key_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_evt
);

    // The entry cycle in IDLE/HELD counts as the first stable sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q, sync_d;
    logic             pressed;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             evt_q;

    always_comb begin
        sync_d = {sync_q[0], key_n};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign pressed = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q <= CHK_PRESS;
                        cnt_q   <= '0;
                    end
                end
                CHK_PRESS: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        evt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_q <= CHK_REL;
                        cnt_q   <= '0;
                    end
                end
                CHK_REL: begin
                    if (pressed) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_evt = evt_q;

endmodule

// File: rtl/key_counter.sv
// Debounced up/down push-button counter with synchronous load, feeding HEX1:HEX0.
// Define KEY_COUNTER_BCD_EN to count as two packed BCD digits (00..99) instead of binary.
module key_counter
    import key_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    key_counter_if.slave  bus
);

`ifdef KEY_COUNTER_BCD_EN
    // Result format for step functions: {wrap, next_value}.
    function automatic logic [8:0] step_up(input logic [7:0] v);
        if (v == BCD_MAX)
            return {1'b1, 8'h00};
        else if (v[3:0] >= 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [8:0] step_dn(input logic [7:0] v);
        if (v == 8'h00)
            return {1'b1, BCD_MAX};
        else if (v[3:0] == 4'd0)
            return {1'b0, v[7:4] - 4'd1, 4'd9};
        else
            return {1'b0, v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] load_fix(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {hi, lo};
    endfunction
`else
    function automatic logic [8:0] step_up(input logic [7:0] v);
        return {v == BIN_MAX, v + 8'd1};
    endfunction

    function automatic logic [8:0] step_dn(input logic [7:0] v);
        return {v == 8'h00, v - 8'd1};
    endfunction

    function automatic logic [7:0] load_fix(input logic [7:0] v);
        return v;
    endfunction
`endif

    logic       up_evt, dn_evt;
    logic [7:0] value_q, value_d;
    logic       step_q, step_d;
    logic       wrap_q, wrap_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_up (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .key_n     (bus.KEY_UP_N),
        .press_evt (up_evt)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dn (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .key_n     (bus.KEY_DN_N),
        .press_evt (dn_evt)
    );

    // LOAD wins over keys; simultaneous up+down cancel out.
    always_comb begin
        value_d = value_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.LOAD) begin
            value_d = load_fix(bus.LOAD_VAL);
        end else if (up_evt && !dn_evt) begin
            {wrap_d, value_d} = step_up(value_q);
            step_d = 1'b1;
        end else if (dn_evt && !up_evt) begin
            {wrap_d, value_d} = step_dn(value_q);
            step_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            value_q <= 8'h00;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.VALUE = value_q;
    assign bus.STEP  = step_q;
    assign bus.WRAP  = wrap_q;

endmodule

// File: tb/tb_key_counter.sv
// Directed bench for key_counter with DEBOUNCE_CYCLES=4; a stability-rule model is checked every cycle.
module tb_key_counter;

    localparam int DEB = 4;
`ifdef KEY_COUNTER_BCD_EN
    localparam int MOD = 100;
`else
    localparam int MOD = 256;
`endif

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    key_counter_if bus ();

    key_counter #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (24)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int to_num(input logic [7:0] v);
`ifdef KEY_COUNTER_BCD_EN
        return int'(v[7:4]) * 10 + int'(v[3:0]);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [7:0] from_num(input int n);
`ifdef KEY_COUNTER_BCD_EN
        return {4'(n / 10), 4'(n % 10)};
`else
        return 8'(n);
`endif
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v);
`ifdef KEY_COUNTER_BCD_EN
        return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4], (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
`else
        return v;
`endif
    endfunction

    // Per key: the synchronised level must differ from the accepted level for DEB
    // consecutive samples before it is accepted; a newly accepted press is an event.
    bit [1:0]   m_s1, m_s2, m_acc, m_evt;
    int         m_run [2];
    logic [7:0] m_val;
    logic       m_step, m_wrap;

    always @(posedge CLOCK_50 or posedge RESET) begin
        bit [1:0] raw, nevt;
        bit       p;
        int       n;
        if (RESET) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_acc = 2'b00; m_evt = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
            m_val = 8'h00; m_step = 1'b0; m_wrap = 1'b0;
        end else begin
            raw = {bus.KEY_DN_N, bus.KEY_UP_N};
            nevt = 2'b00;
            for (int k = 0; k < 2; k++) begin
                p = !m_s2[k];
                if (p != m_acc[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_acc[k] = p;
                        m_run[k] = 0;
                        nevt[k]  = p;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_step = 1'b0;
            m_wrap = 1'b0;
            n = to_num(m_val);
            if (bus.LOAD) begin
                m_val = clamp(bus.LOAD_VAL);
            end else if (m_evt == 2'b01) begin
                m_step = 1'b1;
                m_wrap = (n == MOD - 1);
                m_val  = from_num((n + 1) % MOD);
            end else if (m_evt == 2'b10) begin
                m_step = 1'b1;
                m_wrap = (n == 0);
                m_val  = from_num((n + MOD - 1) % MOD);
            end
            m_evt = nevt;
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    always @(negedge CLOCK_50) begin
        if (armed) begin
            chk("model VALUE", bus.VALUE, m_val);
            chk("model STEP", {7'd0, bus.STEP}, {7'd0, m_step});
            chk("model WRAP", {7'd0, bus.WRAP}, {7'd0, m_wrap});
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input bit up, input bit dn, input string name,
                         input logic [7:0] exp_val, input bit exp_step, input bit exp_wrap);
        if (up) bus.KEY_UP_N = 1'b0;
        if (dn) bus.KEY_DN_N = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        chk({name, " VALUE"}, bus.VALUE, exp_val);
        chk({name, " STEP"}, {7'd0, bus.STEP}, {7'd0, exp_step});
        chk({name, " WRAP"}, {7'd0, bus.WRAP}, {7'd0, exp_wrap});
        repeat (3) @(negedge CLOCK_50);
        bus.KEY_UP_N = 1'b1;
        bus.KEY_DN_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic load(input logic [7:0] v, input logic [7:0] exp, input string name);
        bus.LOAD = 1'b1;
        bus.LOAD_VAL = v;
        @(negedge CLOCK_50);
        bus.LOAD = 1'b0;
        chk(name, bus.VALUE, exp);
    endtask

    initial begin
        bus.KEY_UP_N = 1'b1;
        bus.KEY_DN_N = 1'b1;
        bus.LOAD     = 1'b0;
        bus.LOAD_VAL = 8'h00;
        RESET        = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        armed = 1'b1;
        chk("reset VALUE", bus.VALUE, 8'h00);
        chk("reset STEP", {7'd0, bus.STEP}, 8'h00);

        // Single press: VALUE moves on the 7th edge after the key falls.
        bus.KEY_UP_N = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        chk("latency edge6 VALUE", bus.VALUE, 8'h00);
        @(negedge CLOCK_50);
        chk("latency edge7 VALUE", bus.VALUE, 8'h01);
        chk("latency edge7 STEP", {7'd0, bus.STEP}, 8'h01);
        repeat (3) @(negedge CLOCK_50);
        bus.KEY_UP_N = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        chk("hold once VALUE", bus.VALUE, 8'h01);

        // Bounce every 2 cycles, then settle low.
        for (int i = 0; i < 6; i++) begin
            bus.KEY_UP_N = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge CLOCK_50);
        end
        chk("bounce VALUE", bus.VALUE, 8'h01);
        bus.KEY_UP_N = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        chk("bounce settle VALUE", bus.VALUE, 8'h02);
        bus.KEY_UP_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Wrap in both directions.
`ifdef KEY_COUNTER_BCD_EN
        load(8'hFF, 8'h99, "load FF");
        press(1'b1, 1'b0, "up wrap", 8'h00, 1'b1, 1'b1);
        press(1'b0, 1'b1, "down wrap", 8'h99, 1'b1, 1'b1);
        press(1'b1, 1'b1, "both keys", 8'h99, 1'b0, 1'b0);
`else
        load(8'hFF, 8'hFF, "load FF");
        press(1'b1, 1'b0, "up wrap", 8'h00, 1'b1, 1'b1);
        press(1'b0, 1'b1, "down wrap", 8'hFF, 1'b1, 1'b1);
        press(1'b1, 1'b1, "both keys", 8'hFF, 1'b0, 1'b0);
`endif

        // LOAD coinciding with a press event wins and drops the event.
        bus.KEY_UP_N = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        bus.LOAD = 1'b1;
        bus.LOAD_VAL = 8'h42;
        @(negedge CLOCK_50);
        bus.LOAD = 1'b0;
        chk("load vs event VALUE", bus.VALUE, 8'h42);
        chk("load vs event STEP", {7'd0, bus.STEP}, 8'h00);
        repeat (3) @(negedge CLOCK_50);
        bus.KEY_UP_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Async reset mid-debounce; the held key must be re-debounced afterwards.
        bus.KEY_UP_N = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #5 RESET = 1'b1;
        #1;
        chk("async reset VALUE", bus.VALUE, 8'h00);
        chk("async reset STEP", {7'd0, bus.STEP}, 8'h00);
        chk("async reset WRAP", {7'd0, bus.WRAP}, 8'h00);
        repeat (2) @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        chk("redebounce edge6 VALUE", bus.VALUE, 8'h00);
        @(negedge CLOCK_50);
        chk("redebounce edge7 VALUE", bus.VALUE, 8'h01);
        repeat (3) @(negedge CLOCK_50);
        bus.KEY_UP_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        // Digit carry, top-of-range wrap and load clamping.
`ifdef KEY_COUNTER_BCD_EN
        load(8'h09, 8'h09, "load 09");
        press(1'b1, 1'b0, "carry 09", 8'h10, 1'b1, 1'b0);
        press(1'b0, 1'b1, "borrow 10", 8'h09, 1'b1, 1'b0);
        load(8'h99, 8'h99, "load 99");
        press(1'b1, 1'b0, "up 99", 8'h00, 1'b1, 1'b1);
        load(8'hAF, 8'h99, "load AF");
`else
        load(8'h09, 8'h09, "load 09");
        press(1'b1, 1'b0, "carry 09", 8'h0A, 1'b1, 1'b0);
        press(1'b0, 1'b1, "borrow 0A", 8'h09, 1'b1, 1'b0);
        load(8'h99, 8'h99, "load 99");
        press(1'b1, 1'b0, "up 99", 8'h9A, 1'b1, 1'b0);
        load(8'hAF, 8'hAF, "load AF");
`endif
        repeat (3) @(negedge CLOCK_50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_counter.md
Name: key_counter

Overview:
- Upstream producer for the 7-segment display stage: turns raw DE-board push-buttons into a clean 8-bit value whose low/high nibbles drive the HEX0/HEX1 decoders.
- Two active-low keys (up, down) are synchronised and debounced; each debounced press steps the count once.
- A synchronous load path presets the value from the switches.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a key level must stay stable before it is accepted (20 ms at 50 MHz); legal range 2..2^24-1.
- CNT_W, 24, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEY_UP_N  in  1  raw up button, active-low, asynchronous to CLOCK_50.
- KEY_DN_N  in  1  raw down button, active-low, asynchronous to CLOCK_50.
- LOAD  in  1  synchronous load strobe, active-high.
- LOAD_VAL  in  8  preset value, e.g. SW[7:0].
- VALUE  out  8  current count; [3:0] feeds HEX0 decoder, [7:4] feeds HEX1 decoder.
- STEP  out  1  one-cycle pulse when VALUE changed due to a key.
- WRAP  out  1  one-cycle pulse when a step wrapped (up past max, or down past 0).

Behaviour:
- Reset (async assert, sync release by construction of the flops):
  - VALUE=0, STEP=0, WRAP=0.
  - Synchronisers = 1 (released).
  - Debounce FSMs in IDLE, counters 0.
- Sync: each key passes a 2-flop synchroniser; it is inverted internally to active-high `pressed`.
- Debounce FSM, per key, states IDLE / CHK_PRESS / HELD / CHK_REL:
  - IDLE: pressed=1 -> CHK_PRESS, counter cleared.
  - CHK_PRESS: pressed=0 -> IDLE. Counter reaches DEBOUNCE_CYCLES-1 with pressed=1 -> HELD, emit press event (1 cycle).
  - HELD: pressed=0 -> CHK_REL, counter cleared.
  - CHK_REL: pressed=1 -> HELD. Counter reaches DEBOUNCE_CYCLES-1 with pressed=0 -> IDLE.
  - Holding a key produces exactly one event; there is no auto-repeat.
- Latency: raw press to VALUE update = 2 sync cycles + DEBOUNCE_CYCLES + 1 register cycle.
- Count update, per cycle, in priority order:
  1. LOAD=1: VALUE<=LOAD_VAL. No STEP/WRAP. Key events that cycle are discarded.
  2. up and down events in the same cycle: no change, no STEP/WRAP.
  3. up only: VALUE<=VALUE+1, STEP=1. WRAP=1 when VALUE was 0xFF (-> 0x00).
  4. down only: VALUE<=VALUE-1, STEP=1. WRAP=1 when VALUE was 0x00 (-> 0xFF).
- STEP and WRAP are registered and high for exactly one cycle.
- Reset asserted mid-debounce: the FSM returns to IDLE immediately. A key still held after release of RESET must be re-debounced before it produces an event.

Optional Feature:
- Macro KEY_COUNTER_BCD_EN.
- Defined: VALUE is two packed BCD digits, range 00..99.
  - Up from 0x99 -> 0x00 with WRAP; down from 0x00 -> 0x99 with WRAP.
  - Digit carry/borrow: 0x09+1 -> 0x10; 0x10-1 -> 0x09.
  - LOAD with a nibble >9 clamps that nibble to 9.
- Undefined: plain binary modulo-256 as in Behaviour.

Decomposition:
- Package key_counter_pkg:
  - debounce state enum (IDLE, CHK_PRESS, HELD, CHK_REL);
  - constants BIN_MAX=8'hFF and BCD_MAX=8'h99.
- Sub-module key_debounce: synchroniser + FSM + counter, outputs a 1-cycle press event. Instantiated twice (up, down).
- The count datapath stays in key_counter.

Test Plan (bench uses DEBOUNCE_CYCLES=4, 20 ns clock):
- RESET pulse mid-simulation -> VALUE=0x00, STEP=0, WRAP=0 asynchronously, before the next clock edge.
- KEY_UP_N low 10 cycles then high -> single STEP pulse; VALUE 0x00->0x01 exactly 7 cycles after the falling edge.
- KEY_UP_N bouncing low/high every 2 cycles for 12 cycles, then steady low -> no STEP during the bounce; exactly one increment after stable.
- LOAD=1 with LOAD_VAL=0xFF, then one up press -> VALUE=0x00, WRAP=1 for one cycle. Then one down press -> VALUE=0xFF, WRAP=1.
- Both keys pressed in the same cycle -> simultaneous events, VALUE unchanged, STEP=0. LOAD asserted during a press event -> VALUE=LOAD_VAL, event dropped.
- With KEY_COUNTER_BCD_EN:
  - LOAD_VAL=0x09 + up -> 0x10;
  - LOAD_VAL=0x99 + up -> 0x00 with WRAP;
  - LOAD_VAL=0xAF -> VALUE=0x99.
